// File: rtl/score_bcd_scheduler_if.sv
// Request/result bundle between the score sources and the shared BCD converter.
// The master drives the requests; the slave (converter) returns digits, flags and pulses.
interface score_bcd_scheduler_if #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
);
    logic                  req0;
    logic [WIDTH-1:0]      val0;
    logic                  req1;
    logic [WIDTH-1:0]      val1;
    logic                  busy;
    logic                  done0;
    logic                  done1;
    logic [4*DIGITS-1:0]   bcd0;
    logic [4*DIGITS-1:0]   bcd1;
    logic                  ovf0;
    logic                  ovf1;

    modport master (
        output req0, val0, req1, val1,
        input  busy, done0, done1, bcd0, bcd1, ovf0, ovf1
    );

    modport slave (
        input  req0, val0, req1, val1,
        output busy, done0, done1, bcd0, bcd1, ovf0, ovf1
    );
endinterface

// File: rtl/score_bcd_scheduler.sv
// One shift-and-add-3 binary-to-BCD converter shared round-robin by two score sources,
// each with its own registered digit bank, overflow flag and done pulse.
module score_bcd_scheduler #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    score_bcd_scheduler_if.slave  bus
);

    // The accumulator must hold every digit of 2^WIDTH-1 and at least DIGITS digits.
    localparam int NEED_D = (WIDTH + 2) / 3;
    localparam int ACC_D  = (NEED_D > DIGITS) ? NEED_D : DIGITS;
    localparam int ACC_W  = 4 * ACC_D;
    localparam int CNT_W  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state;
    logic [WIDTH-1:0]     bin_reg;
    logic [ACC_W-1:0]     acc;
    logic [CNT_W-1:0]     count;
    logic                 owner;
    logic                 last;
    logic [4*DIGITS-1:0]  bcd0_q;
    logic [4*DIGITS-1:0]  bcd1_q;
    logic                 ovf0_q;
    logic                 ovf1_q;
    logic                 done0_q;
    logic                 done1_q;

    logic [ACC_W-1:0]     acc_adj;
    logic [4*DIGITS-1:0]  result_bcd;
    logic                 result_ovf;
    logic                 pick1;

    function automatic logic [ACC_W-1:0] add3(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        r = a;
        for (int i = 0; i < ACC_D; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign acc_adj = add3(acc);

    // Requester 1 wins when alone, or when both ask and requester 0 was served last.
    assign pick1 = bus.req1 && (!bus.req0 || !last);

    // Any nonzero digit above the visible ones means the value does not fit: saturate to all 9s.
    always_comb begin
        result_bcd = '0;
        result_ovf = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            result_bcd[4*i +: 4] = acc[4*i +: 4];
        end
        for (int i = DIGITS; i < ACC_D; i++) begin
            if (acc[4*i +: 4] != 4'd0) begin
                result_ovf = 1'b1;
            end
        end
        if (result_ovf) begin
            result_bcd = {DIGITS{4'h9}};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            bin_reg <= '0;
            acc     <= '0;
            count   <= '0;
            owner   <= 1'b0;
            last    <= 1'b1;
            bcd0_q  <= '0;
            bcd1_q  <= '0;
            ovf0_q  <= 1'b0;
            ovf1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        owner   <= pick1;
                        last    <= pick1;
                        bin_reg <= pick1 ? bus.val1 : bus.val0;
                        acc     <= '0;
                        count   <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc     <= {acc_adj[ACC_W-2:0], bin_reg[WIDTH-1]};
                    bin_reg <= bin_reg << 1;
                    count   <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (owner) begin
                        bcd1_q  <= result_bcd;
                        ovf1_q  <= result_ovf;
                        done1_q <= 1'b1;
                    end else begin
                        bcd0_q  <= result_bcd;
                        ovf0_q  <= result_ovf;
                        done0_q <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.done0 = done0_q;
    assign bus.done1 = done1_q;
    assign bus.bcd0  = bcd0_q;
    assign bus.bcd1  = bcd1_q;
    assign bus.ovf0  = ovf0_q;
    assign bus.ovf1  = ovf1_q;

endmodule

// File: doc/score_bcd_scheduler.md
Name: score_bcd_scheduler

Overview:
Shares one iterative (shift-and-add-3) binary-to-BCD converter between two score requesters, e.g. the live player score and the stored high score. A round-robin arbiter grants the converter, and each requester gets its own registered BCD digit bank plus a one-cycle done pulse. The block sits between the game score logic and the 7-segment digit drivers, replacing one divider-based converter per score source.

Parameters:
WIDTH, 10, binary score width in bits
DIGITS, 4, number of BCD digits per result; 4*DIGITS output bits

Ports:
clk  in  1  system clock; all state on rising edge
resetn  in  1  asynchronous active-low reset
req0  in  1  requester 0 conversion request (level)
val0  in  WIDTH  requester 0 binary value; sampled only at grant
req1  in  1  requester 1 conversion request (level)
val1  in  WIDTH  requester 1 binary value; sampled only at grant
busy  out  1  converter occupied (state != IDLE)
done0  out  1  one-cycle pulse: bcd0/ovf0 updated
done1  out  1  one-cycle pulse: bcd1/ovf1 updated
bcd0  out  4*DIGITS  requester 0 digits; [3:0]=units, [7:4]=tens, etc.
bcd1  out  4*DIGITS  requester 1 digits, same packing
ovf0  out  1  last requester 0 value exceeded 10^DIGITS-1
ovf1  out  1  last requester 1 value exceeded 10^DIGITS-1

Behaviour:
- Reset (resetn low, async): state=IDLE, bcd0=bcd1=0, ovf0=ovf1=0, done0=done1=0, busy=0, shift/count regs=0, round-robin pointer "last=1" (requester 0 wins first tie). Reset mid-conversion aborts it; no done pulse and no digit update.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: edge with any req high -> grant, latch valN into shift reg, clear BCD accumulator, count=0, go to SHIFT. Neither req high -> stay.
- Arbitration: exactly one req -> grant it. Both high -> grant the one that is not "last"; "last" updates at grant.
- SHIFT: each edge does the add-3 step (every BCD nibble >=5 gets +3), then a 1-bit left shift of {accumulator, binary}. After WIDTH edges -> DONE. The accumulator is wide enough for the full WIDTH-bit range; its internal width is free.
- DONE, single edge: compute the result and write it to the granted bank only. If the latched value is <=10^DIGITS-1, write the exact digits and clear ovf. Otherwise write all digits 9 (saturate) and set ovf. Pulse doneN high for exactly this next cycle, then go to IDLE.
- Latency: grant-sampling edge E0, done/bcd visible after edge E0+WIDTH+1, i.e. WIDTH+2 cycles (12 at default). bcdN changes only on that edge; it holds otherwise.
- Throughput: the next grant can be taken at the first edge in IDLE, so there is one conversion per WIDTH+2 cycles. With both reqs held high, grants alternate 0,1,0,1.
- req is not consumed: a held request is re-served continuously as a periodic refresh. Dropping req mid-conversion does not cancel it; the result is still written.
- valN changes after grant have no effect on the conversion in progress.
- done0 and done1 are never high in the same cycle. busy is high in SHIFT and DONE.
- Other bank is untouched by a conversion; its ovf is also untouched.

Test Plan:
- Reset -> all outputs 0; release resetn; req0=1 val0=1023 one cycle -> busy next cycle, done0 single pulse 12 cycles after grant edge, bcd0=0x1023, ovf0=0, bcd1 stays 0.
- val0=0, then val0=9, then val0=999, each a separate request -> bcd0=0x0000, 0x0009, 0x0999 in turn, each with its own done0 pulse.
- req0 and req1 rise together, val0=42, val1=517 -> done0 with bcd0=0x0042, then done1 exactly 12 cycles later with bcd1=0x0517.
- Both reqs held high for 60 cycles -> done pulses alternate 0,1,0,1,0, spaced 12 cycles apart; a val1 change mid-conversion affects only the next grant of requester 1.
- DIGITS=3 instance, val0=1000 -> bcd0=0x999, ovf0=1; next val0=250 -> bcd0=0x250, ovf0=0.
- Assert resetn low 5 cycles into a req1 conversion -> no done1 pulse, bcd1=0, busy=0. After release with req0 high, requester 0 is granted first.
